// File: rtl/fnd_scan_decoder_if.sv
// Bus bundle for the FND scan decoder: multiplexed 7-segment inputs plus the rebuilt frame and status outputs.
// The decoder uses the slave view; a display driver model or bench uses the master view.
interface fnd_scan_decoder_if;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;
    logic [15:0] o_digits;
    logic [3:0]  o_dp;
    logic [3:0]  o_blank;
    logic        o_frame_valid;
    logic        o_seg_err;
    logic        o_sel_err;
    logic        o_timeout;
    logic [1:0]  dbg_state;

    modport slave (
        input  fnd_digit, fnd_data,
        output o_digits, o_dp, o_blank, o_frame_valid, o_seg_err, o_sel_err, o_timeout, dbg_state
    );

    modport master (
        output fnd_digit, fnd_data,
        input  o_digits, o_dp, o_blank, o_frame_valid, o_seg_err, o_sel_err, o_timeout, dbg_state
    );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus, rebuilds the four hex digits and reports each complete frame.
// Optional FND_DEC_CHANGE_ONLY_EN: publish (and pulse o_frame_valid) only when the frame differs from the outputs.
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    fnd_scan_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    ACC_AT  = 8'(SETTLE_CYCLES - 2);
    localparam logic [7:0]    HOLD_AT = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, PUBLISH = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    r_sel_q, r_sel_d;
    logic [7:0]    r_seg_q, r_seg_d;
    logic [11:0]   prev_q, prev_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   sh_dig_q, sh_dig_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic [15:0]   dig_q, dig_d;
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    blank_q, blank_d;
    logic          fv_q, fv_d;
    logic          seg_err_q, seg_err_d;
    logic          sel_err_q, sel_err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [3:0] nib;
    logic       glyph_blank;
    logic       legal;
    logic [1:0] idx;
    logic       sel_one;
    logic       sel_idle;
    logic       changed;
    logic       accept;
    logic       publish_upd;
    logic [3:0] seen_acc;

    always_comb begin
        nib         = 4'h0;
        glyph_blank = 1'b0;
        legal       = 1'b1;
        case (r_seg_q[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h7F: glyph_blank = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        sel_one = 1'b1;
        idx     = 2'd0;
        case (r_sel_q)
            4'hE: idx = 2'd0;
            4'hD: idx = 2'd1;
            4'hB: idx = 2'd2;
            4'h7: idx = 2'd3;
            default: sel_one = 1'b0;
        endcase
    end

    assign sel_idle = (r_sel_q == 4'hF);
    assign changed  = ({r_sel_q, r_seg_q} != prev_q);
    // One accept per dwell: fires only on the step into HOLD_AT, where the counter then parks.
    assign accept   = sel_one && !changed && (cnt_q == ACC_AT);
    assign seen_acc = seen_q | ~r_sel_q;

`ifdef FND_DEC_CHANGE_ONLY_EN
    assign publish_upd = ({sh_dig_q, sh_dp_q, sh_blank_q} != {dig_q, dp_q, blank_q});
`else
    assign publish_upd = 1'b1;
`endif

    always_comb begin
        r_sel_d    = bus.fnd_digit;
        r_seg_d    = bus.fnd_data;
        prev_d     = {r_sel_q, r_seg_q};
        state_d    = state_q;
        seen_d     = seen_q;
        sh_dig_d   = sh_dig_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        dig_d      = dig_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        fv_d       = 1'b0;
        seg_err_d  = accept && !legal;
        sel_err_d  = !sel_idle && !sel_one && (r_sel_q != prev_q[11:8]);

        if (changed || sel_idle) begin
            cnt_d = 8'd0;
        end else if (cnt_q != HOLD_AT) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        for (int i = 0; i < 4; i++) begin
            if (accept && idx == 2'(i)) begin
                sh_dig_d[4*i +: 4] = nib;
                sh_dp_d[i]         = ~r_seg_q[7];
                sh_blank_d[i]      = glyph_blank;
            end
        end

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    seen_d  = seen_acc;
                    state_d = (seen_acc == 4'hF) ? PUBLISH : COLLECT;
                end
            end
            PUBLISH: begin
                if (publish_upd) begin
                    dig_d   = sh_dig_q;
                    dp_d    = sh_dp_q;
                    blank_d = sh_blank_q;
                    fv_d    = 1'b1;
                end
                seen_d  = accept ? ~r_sel_q : 4'h0;
                state_d = accept ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Publishing always restarts the watchdog, so a frame landing on expiry wins.
        if (state_q == PUBLISH) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            r_sel_q    <= 4'hF;
            r_seg_q    <= 8'hFF;
            prev_q     <= 12'hFFF;
            cnt_q      <= 8'd0;
            seen_q     <= 4'h0;
            sh_dig_q   <= 16'h0;
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'h0;
            dig_q      <= 16'h0;
            dp_q       <= 4'h0;
            blank_q    <= 4'h0;
            fv_q       <= 1'b0;
            seg_err_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            r_sel_q    <= r_sel_d;
            r_seg_q    <= r_seg_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            sh_dig_q   <= sh_dig_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            dig_q      <= dig_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            fv_q       <= fv_d;
            seg_err_q  <= seg_err_d;
            sel_err_q  <= sel_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.o_digits      = dig_q;
    assign bus.o_dp          = dp_q;
    assign bus.o_blank       = blank_q;
    assign bus.o_frame_valid = fv_q;
    assign bus.o_seg_err     = seg_err_q;
    assign bus.o_sel_err     = sel_err_q;
    assign bus.o_timeout     = (tmo_q == TMO_MAX);
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: drives scan sequences on the 7-segment bus and checks the rebuilt frames.
// Expected values are hand-computed from the glyph table for SETTLE_CYCLES=4, TIMEOUT_CYCLES=200.
module tb_fnd_scan_decoder;
    localparam int SETTLE = 4;
    localparam int TMO    = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fnd_scan_decoder_if bus();

    fnd_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt      = 0;
    int seg_err_cnt = 0;
    int sel_err_cnt = 0;

    always @(negedge clk) begin
        if (bus.o_frame_valid) fv_cnt++;
        if (bus.o_seg_err) seg_err_cnt++;
        if (bus.o_sel_err) sel_err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic show(input logic [3:0] sel, input logic [7:0] seg, input int n);
        bus.fnd_digit = sel;
        bus.fnd_data  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        show(4'hF, 8'hFF, n);
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        show(4'hE, d0, 10);
        show(4'hD, d1, 10);
        show(4'hB, d2, 10);
        show(4'h7, d3, 10);
        idle(4);
    endtask

    task automatic wait_frame(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_frame_valid) begin
                got = 1'b1;
                cyc = i;
            end
        end
    endtask

    task automatic reset_dut();
        idle(1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
    endtask

    initial begin
        int f0, s0, e0, n;
        bit got;
        int cyc;

        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.fnd_digit = 4'($urandom_range(0, 15));
            bus.fnd_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        check_eq("rst_digits", 32'(bus.o_digits), 32'h0);
        check_eq("rst_dp_blank", 32'({bus.o_dp, bus.o_blank}), 32'h0);
        check_eq("rst_flags", 32'({bus.o_frame_valid, bus.o_seg_err, bus.o_sel_err, bus.o_timeout}), 32'h0);
        check_eq("rst_pulses", 32'(fv_cnt + seg_err_cnt + sel_err_cnt), 32'h0);
        check_eq("rst_state", 32'(bus.dbg_state), 32'h0);
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        reset = 1'b1;
        idle(2);

        // Three digits alone must not complete a frame; a reset then discards them.
        f0 = fv_cnt;
        show(4'hE, 8'hF9, 10);
        show(4'hD, 8'hA4, 10);
        show(4'hB, 8'h30, 10);
        idle(3);
        check_eq("partial_no_frame", 32'(fv_cnt - f0), 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        show(4'h7, 8'h99, 10);
        idle(4);
        check_eq("midreset_no_frame", 32'(fv_cnt - f0), 32'h0);
        check_eq("midreset_digits", 32'(bus.o_digits), 32'h0);
        reset_dut();

        f0 = fv_cnt;
        s0 = seg_err_cnt;
        scan(8'hF9, 8'hA4, 8'h30, 8'h99);
        check_eq("normal_pulses", 32'(fv_cnt - f0), 32'h1);
        check_eq("normal_digits", 32'(bus.o_digits), 32'h4321);
        check_eq("normal_dp", 32'(bus.o_dp), 32'b0100);
        check_eq("normal_blank", 32'(bus.o_blank), 32'h0);
        check_eq("normal_seg_err", 32'(seg_err_cnt - s0), 32'h0);

        f0 = fv_cnt;
        show(4'hE, 8'hF9, 10);
        show(4'hD, 8'hA4, 6);
        show(4'hD, 8'h80, 2);
        show(4'hD, 8'hA4, 6);
        show(4'hB, 8'h30, 10);
        show(4'h7, 8'h99, 10);
        idle(4);
        check_eq("glitch_pulses", 32'(fv_cnt - f0), 32'h1);
        check_eq("glitch_digit1", 32'(bus.o_digits[7:4]), 32'h2);

        f0 = fv_cnt;
        show(4'hE, 8'hF9, 10);
        show(4'hD, 8'h80, 3);
        show(4'hB, 8'h30, 10);
        show(4'h7, 8'h99, 10);
        idle(4);
        check_eq("short_dwell_no_frame", 32'(fv_cnt - f0), 32'h0);
        show(4'hD, 8'hA4, 10);
        idle(4);
        check_eq("short_dwell_complete", 32'(fv_cnt - f0), 32'h1);
        check_eq("short_dwell_digits", 32'(bus.o_digits), 32'h4321);

        scan(8'hF9, 8'hA4, 8'h30, 8'hFF);
        check_eq("blank_digits", 32'(bus.o_digits), 32'h0321);
        check_eq("blank_mask", 32'(bus.o_blank), 32'b1000);
        check_eq("blank_dp", 32'(bus.o_dp), 32'b0100);

        s0 = seg_err_cnt;
        scan(8'h55, 8'hA4, 8'h30, 8'h99);
        check_eq("seg_err_pulses", 32'(seg_err_cnt - s0), 32'h1);
        check_eq("seg_err_digits", 32'(bus.o_digits), 32'h4320);
        check_eq("seg_err_dp", 32'(bus.o_dp), 32'b0101);
        check_eq("seg_err_blank", 32'(bus.o_blank), 32'h0);

        f0 = fv_cnt;
        e0 = sel_err_cnt;
        show(4'hC, 8'hF9, 10);
        show(4'hD, 8'hA4, 10);
        show(4'hB, 8'h30, 10);
        show(4'h7, 8'h99, 10);
        idle(4);
        check_eq("sel_err_pulses", 32'(sel_err_cnt - e0), 32'h1);
        check_eq("sel_err_no_capture", 32'(fv_cnt - f0), 32'h0);
        show(4'hE, 8'hF9, 10);
        idle(4);
        check_eq("sel_err_then_frame", 32'(fv_cnt - f0), 32'h1);
        check_eq("sel_err_digits", 32'(bus.o_digits), 32'h4321);

        show(4'hE, 8'hF9, 10);
        show(4'hD, 8'hA4, 10);
        show(4'hB, 8'h30, 10);
        bus.fnd_digit = 4'h7;
        bus.fnd_data  = 8'h99;
        wait_frame(got, cyc);
        check_eq("latency_got", 32'(got), 32'h1);
        check_eq("latency_cycles", 32'(cyc), 32'(SETTLE + 2));
        check_eq("frame_timeout_low", 32'(bus.o_timeout), 32'h0);
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        n = 0;
        while (!bus.o_timeout && n < 2 * TMO) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check_eq("frame_valid_one_cycle", 32'(bus.o_frame_valid), 32'h0);
        end
        check_eq("timeout_cycles", 32'(n), 32'(TMO));
        idle(20);
        check_eq("timeout_held", 32'(bus.o_timeout), 32'h1);

        show(4'hE, 8'hF9, 10);
        show(4'hD, 8'hA4, 10);
        show(4'hB, 8'h30, 10);
        check_eq("timeout_before_resume", 32'(bus.o_timeout), 32'h1);
        bus.fnd_digit = 4'h7;
        bus.fnd_data  = 8'h99;
        wait_frame(got, cyc);
        check_eq("resume_got", 32'(got), 32'h1);
        check_eq("resume_timeout_drop", 32'(bus.o_timeout), 32'h0);
        idle(4);

        scan(8'hF9, 8'hA4, 8'h30, 8'hFF);
        f0 = fv_cnt;
        for (int r = 0; r < 3; r++) scan(8'hF9, 8'hA4, 8'h30, 8'h99);
`ifdef FND_DEC_CHANGE_ONLY_EN
        check_eq("repeat_pulses", 32'(fv_cnt - f0), 32'h1);
`else
        check_eq("repeat_pulses", 32'(fv_cnt - f0), 32'h3);
`endif
        check_eq("repeat_digits", 32'(bus.o_digits), 32'h4321);
        f0 = fv_cnt;
        scan(8'h92, 8'hA4, 8'h30, 8'h99);
        check_eq("change_pulse", 32'(fv_cnt - f0), 32'h1);
        check_eq("change_digits", 32'(bus.o_digits), 32'h4325);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
